// File: rtl/sum_arbiter_pkg.sv
// rtl/sum_arbiter_pkg.sv - shared types, defaults and pointer helper for sum_arbiter
package sum_arbiter_pkg;

  typedef enum logic {IDLE, HOLD} state_e;

  localparam int SUM_N_REQ = 4;
  localparam int SUM_W     = 8;

  function automatic int next_ptr(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/sum_arbiter_rr.sv
// rtl/sum_arbiter_rr.sv - combinational round-robin grant search starting at ptr
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
    // gnt_idx is still computed when disabled so the datapath mux stays simple
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/sum_arbiter.sv
// rtl/sum_arbiter.sv - round-robin shared registered adder; SUM_ARBITER_SAT_EN saturates on carry
module sum_arbiter
  import sum_arbiter_pkg::*;
#(
  parameter  int N_REQ = SUM_N_REQ,
  parameter  int W     = SUM_W,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_y,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_carry,
  output logic               busy
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [W-1:0]    y_q, y_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            carry_q, carry_d;

  logic            can_issue;
  logic            arb_en;
  logic            accept;
  logic [ID_W-1:0] gnt_idx;
  logic [W-1:0]    a_g, b_g, y_new;
  logic [W:0]      sum;

  assign can_issue = (state_q == IDLE) || rsp_ready;
  assign arb_en    = can_issue && !rst;
  assign accept    = arb_en && (|req_valid);

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign a_g = req_a[int'(gnt_idx)*W +: W];
  assign b_g = req_b[int'(gnt_idx)*W +: W];
  assign sum = {1'b0, a_g} + {1'b0, b_g};

`ifdef SUM_ARBITER_SAT_EN
  assign y_new = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
  assign y_new = sum[W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    y_d     = y_q;
    id_d    = id_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = HOLD;
      end
      HOLD: begin
        if (rsp_ready && !accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      y_d     = y_new;
      carry_d = sum[W];
      id_d    = gnt_idx;
      ptr_d   = ID_W'(next_ptr(int'(gnt_idx), N_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      y_q     <= '0;
      id_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      id_q    <= id_d;
      carry_q <= carry_d;
    end
  end

  assign rsp_valid = (state_q == HOLD);
  assign busy      = (state_q == HOLD);
  assign rsp_y     = y_q;
  assign rsp_id    = id_q;
  assign rsp_carry = carry_q;

endmodule

// File: tb/tb_sum_arbiter.sv
// tb/tb_sum_arbiter.sv - directed self-checking bench for sum_arbiter (N_REQ=4, W=8)
module tb_sum_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;
  logic        rsp_carry;
  logic        busy;

  logic [7:0]  a_arr [4];
  logic [7:0]  b_arr [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = a_arr[i];
      req_b[i*8 +: 8] = b_arr[i];
    end
  end

  sum_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id),
    .rsp_carry (rsp_carry),
    .busy      (busy)
  );

  // Tasks start and end one time unit after a rising edge.
  task automatic pulse_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin a_arr[i] = 8'h00; b_arr[i] = 8'h00; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_y !== 8'h00) begin failures++; $display("FAIL reset_y got=%h exp=00", rsp_y); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", rsp_id); end
    checks++; if (rsp_carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", rsp_carry); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL reset_release_ready got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_single_op();
    req_valid = 4'b0010;
    a_arr[1] = 8'd1; b_arr[1] = 8'd2;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_y !== 8'd3) begin failures++; $display("FAIL single_y got=%h exp=03", rsp_y); end
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL single_id got=%0d exp=1", rsp_id); end
    checks++; if (rsp_carry !== 1'b0) begin failures++; $display("FAIL single_carry got=%b exp=0", rsp_carry); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    checks++; if (rsp_y !== 8'd3) begin failures++; $display("FAIL single_idle_y_kept got=%h exp=03", rsp_y); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [7:0] exp_y;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 8'(i + 1);
      b_arr[i] = 8'(16 * i);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      exp_y   = 8'(17 * (k % 4) + 1);
      @(negedge clk);
      checks++; if (req_ready !== exp_gnt) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_gnt); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, rsp_valid); end
      checks++; if (rsp_id !== 2'(k % 4)) begin failures++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, rsp_id, k % 4); end
      checks++; if (rsp_y !== exp_y) begin failures++; $display("FAIL rr_y[%0d] got=%h exp=%h", k, rsp_y, exp_y); end
    end
    req_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    a_arr[0] = 8'hAA; b_arr[0] = 8'h55;
    a_arr[1] = 8'h03; b_arr[1] = 8'h04;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, rsp_valid); end
      checks++; if (rsp_y !== 8'hFF) begin failures++; $display("FAIL bp_y[%0d] got=%h exp=ff", c, rsp_y); end
      checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL bp_id[%0d] got=%0d exp=0", c, rsp_id); end
      checks++; if (rsp_carry !== 1'b0) begin failures++; $display("FAIL bp_carry[%0d] got=%b exp=0", c, rsp_carry); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL bp_release_id got=%0d exp=1", rsp_id); end
    checks++; if (rsp_y !== 8'h07) begin failures++; $display("FAIL bp_release_y got=%h exp=07", rsp_y); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] ey [3];
    logic       ec [3];
    va[0] = 8'hFF; vb[0] = 8'h01; ec[0] = 1'b1;
    va[1] = 8'h80; vb[1] = 8'h80; ec[1] = 1'b1;
    va[2] = 8'h7F; vb[2] = 8'h80; ec[2] = 1'b0;
`ifdef SUM_ARBITER_SAT_EN
    ey[0] = 8'hFF; ey[1] = 8'hFF; ey[2] = 8'hFF;
`else
    ey[0] = 8'h00; ey[1] = 8'h00; ey[2] = 8'hFF;
`endif
    pulse_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    a_arr[2] = va[0]; b_arr[2] = vb[0];
    for (int v = 0; v < 3; v++) begin
      @(posedge clk); #1;
      checks++; if (rsp_y !== ey[v]) begin failures++; $display("FAIL ovf_y[%0d] got=%h exp=%h", v, rsp_y, ey[v]); end
      checks++; if (rsp_carry !== ec[v]) begin failures++; $display("FAIL ovf_carry[%0d] got=%b exp=%b", v, rsp_carry, ec[v]); end
      checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL ovf_id[%0d] got=%0d exp=2", v, rsp_id); end
      if (v < 2) begin a_arr[2] = va[v+1]; b_arr[2] = vb[v+1]; end
    end
    req_valid = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    a_arr[0] = 8'h01; b_arr[0] = 8'h01;
    a_arr[2] = 8'h10; b_arr[2] = 8'h20;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_hold_valid got=%b exp=1", rsp_valid); end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    checks++; if (rsp_y !== 8'h00) begin failures++; $display("FAIL mid_rst_y got=%h exp=00", rsp_y); end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr_zero got=%b exp=0001", req_ready); end
    req_valid = 4'b1100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_ready got=%b exp=0100", req_ready); end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL mid_id got=%0d exp=2", rsp_id); end
    checks++; if (rsp_y !== 8'h30) begin failures++; $display("FAIL mid_y got=%h exp=30", rsp_y); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
